mips_multicycle_control: RTL
============================

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 SHALL provide parameter OP_RTYPE, default 6'h00, meaning R-type opcode (add/sub/and/or/sll/srl via func).
REQ-002 SHALL provide parameter OP_LW, default 6'h23, meaning load word.
REQ-003 SHALL provide parameter OP_SW, default 6'h2B, meaning store word.
REQ-004 SHALL provide parameter OP_BEQ, default 6'h04, meaning branch-if-equal.
REQ-005 SHALL provide parameter OP_J, default 6'h02, meaning jump.
REQ-006 SHALL have one clock and asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-007 SHALL have these inputs: opcode input 6, instruction[31:26] from the IR; mem_ready input 1, memory access completes this cycle.
REQ-008 SHALL have these 1-bit outputs: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, each a datapath enable or mux select.
REQ-009 SHALL have these 2-bit outputs: ALUOp, the ALU-control class (00 add, 01 sub, 10 R-type func decode); ALUSrcB (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2); PCSource (00 ALU result, 01 ALUOut, 10 jump target).
REQ-010 SHALL have these status outputs: state output 4, current state code; instr_done output 1, one-cycle pulse on the last cycle of each instruction; illegal_op output 1, one-cycle pulse when DECODE sees an unsupported opcode.

Function
REQ-011 SHALL be a Moore FSM; all outputs SHALL be decoded from the registered state only, except the mem_ready qualification in REQ-013.
REQ-012 SHALL use these state codes: RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10; codes 11-15 SHALL go to FETCH next cycle with all outputs 0.
REQ-013 SHALL, in FETCH, drive MemRead=1, ALUSrcB=01, ALUOp=00, IRWrite=PCWrite=mem_ready, and advance to DECODE only when mem_ready=1; otherwise it SHALL hold FETCH.
REQ-014 SHALL, in DECODE, drive ALUSrcB=11, ALUOp=00; next state SHALL be lw/sw->MEMADR, R-type->EXEC, beq->BRANCH, j->JUMP, any other opcode->FETCH with illegal_op=1.
REQ-015 SHALL, in MEMADR, drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state SHALL be MEMRD for lw and MEMWR for sw.
REQ-016 SHALL, in MEMRD, drive MemRead=1, IorD=1, hold until mem_ready=1, then go to MEMWB.
REQ-017 SHALL, in MEMWB, drive RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1, then go to FETCH.
REQ-018 SHALL, in MEMWR, drive MemWrite=1, IorD=1, hold until mem_ready=1, then go to FETCH with instr_done=1 on the mem_ready cycle.
REQ-019 SHALL, in EXEC, drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RWB.
REQ-020 SHALL, in RWB, drive RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1, then go to FETCH.
REQ-021 SHALL, in BRANCH, drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1, then go to FETCH.
REQ-022 SHALL, in JUMP, drive PCWrite=1, PCSource=10, instr_done=1, then go to FETCH.
REQ-023 SHALL drive every output not listed for a state to 0.
REQ-024 SHALL, with zero wait states, take these cycles from FETCH entry to the next FETCH entry: lw 5, sw 4, R-type 4, beq 3, j 3; each mem_ready=0 cycle SHALL add exactly one cycle.
REQ-025 SHALL never assert MemRead and MemWrite together, nor RegWrite together with PCWrite.
REQ-026 SHALL sample opcode only in DECODE (and MEMADR for the lw/sw split); opcode changes in other states SHALL have no effect.

Reset
REQ-027 SHALL, while rst_n=0, immediately force state=RST and all outputs 0, independent of clk.
REQ-028 SHALL leave RST for FETCH on the first rising clk edge after rst_n deasserts; RST SHALL not be re-entered except by reset.
REQ-029 SHALL, on reset asserted mid-instruction (e.g. in MEMWR), drop MemWrite/RegWrite/PCWrite within the same cycle, with no partial commit.

Verification
REQ-030 SHALL cover reset: rst_n=0 with clk running -> state=0, all outputs 0; release -> FETCH next edge with MemRead=1.
REQ-031 SHALL cover lw: opcode=6'h23, mem_ready=1 -> states 1,2,3,4,5, then 1; ALUOp 00,00,00,00,00; RegWrite=1 with MemtoReg=1 only in state 5.
REQ-032 SHALL cover R-type then beq: opcode=0 -> EXEC with ALUOp=10, RWB with RegDst=1; opcode=6'h04 -> BRANCH with ALUOp=01, PCWriteCond=1, total 3 cycles.
REQ-033 SHALL cover wait states: sw with mem_ready=0 for 3 cycles in MEMWR -> MemWrite held 4 cycles, instr_done pulses once, total 7 cycles.
REQ-034 SHALL cover an illegal opcode: opcode=6'h3F in DECODE -> illegal_op pulse, next state FETCH, no RegWrite/MemWrite.
REQ-035 SHALL cover reset mid-instruction: rst_n low during MEMWR -> MemWrite=0 before the next edge; restart sequence matches REQ-030.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode and the
// per-class execute steps; datapath controls decode from the registered state.
`timescale 1ns/1ps
module mips_multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_e;

    state_e state_q;
    state_e state_d;

    assign state = state_q;

    // State register; reset parks the FSM in RST so every decoded output drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode from the current state (mem_ready only qualifies waits).
    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else begin
                    state_d    = S_FETCH;
                    illegal_op = 1'b1;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule
